// File: rtl/alu_pkg.sv
// Shared ALU definitions: conversion FSM states, ALU function codes and
// double-dabble adjustment constants.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10,
        DIV = 2'b11
    } alu_func_t;

    localparam int unsigned BCD_ADJ_THRESH = 5;
    localparam int unsigned BCD_ADJ        = 3;

endpackage

// File: rtl/alu_result_bcd_if.sv
// Handshake and data bundle between the ALU result register and the BCD
// converter. master drives requests, slave returns the converted result.
interface alu_result_bcd_if #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned DIGITS = 4
);

    logic                    start;
    logic [2*WIDTH-1:0]      value;
    logic                    ovf_in;
    logic                    busy;
    logic                    done;
    logic [4*DIGITS-1:0]     bcd;
    logic                    neg;
    logic                    err;

    modport master (
        output start, value, ovf_in,
        input  busy, done, bcd, neg, err
    );

    modport slave (
        input  start, value, ovf_in,
        output busy, done, bcd, neg, err
    );

endinterface

// File: rtl/alu_result_bcd_digit_adj.sv
// Single BCD digit pre-shift correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import alu_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // add-3 correction for digits at or above the threshold
    always_comb begin
        dout = din;
        if (din >= 4'(BCD_ADJ_THRESH)) begin
            dout = din + 4'(BCD_ADJ);
        end
    end

endmodule

// File: rtl/alu_result_bcd.sv
// Converts the registered two's-complement ALU result into sign plus packed
// BCD magnitude, one result bit per clock (shift-and-add-3).
module alu_result_bcd
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_bcd_if.slave   bus
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(W2 + 1);

    state_t          state;
    state_t          state_nxt;

    logic [W2-1:0]   mag;
    logic [BW-1:0]   acc;
    logic [BW-1:0]   acc_adj;
    logic [BW-1:0]   acc_shl;
    logic [CW-1:0]   cnt;
    logic            sign_r;
    logic            ovf_r;

    logic [W2-1:0]   mag_in;

    logic            busy_r;
    logic            done_r;
    logic [BW-1:0]   bcd_r;
    logic            neg_r;
    logic            err_r;

    // Top digit's adjusted MSB is shifted out; with a legal DIGITS it is always 0.
    logic            unused_acc_msb;

    assign mag_in         = bus.value[W2-1] ? (~bus.value + W2'(1)) : bus.value;
    assign acc_shl        = {acc_adj[BW-2:0], mag[W2-1]};
    assign unused_acc_msb = acc_adj[BW-1];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (acc[4*g +: 4]),
                .dout (acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // next-state decode: the shift that takes cnt from 1 to 0 is the last one
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)     state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
            DONE:                       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // state register, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mag    <= '0;
            acc    <= '0;
            cnt    <= '0;
            sign_r <= 1'b0;
            ovf_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            bcd_r  <= '0;
            neg_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            // outputs are decoded from the next state so they line up with it
            busy_r <= (state_nxt != IDLE);
            done_r <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mag    <= mag_in;
                        sign_r <= bus.value[W2-1];
                        ovf_r  <= bus.ovf_in;
                        acc    <= '0;
                        cnt    <= CW'(W2);
                    end
                end
                SHIFT: begin
                    acc <= acc_shl;
                    mag <= {mag[W2-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                    // result registers load with the final shift so they are valid while done is high
                    if (state_nxt == DONE) begin
                        bcd_r <= acc_shl;
                        neg_r <= sign_r;
                        err_r <= ovf_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.bcd  = bcd_r;
    assign bus.neg  = neg_r;
    assign bus.err  = err_r;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Directed-vector bench for the ALU result to BCD converter.
module tb_alu_result_bcd;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_bcd_if #(.WIDTH(6), .DIGITS(4)) bus ();

    alu_result_bcd #(.WIDTH(6), .DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion. inj_at: cycle at which a stray start is pulsed (0 = none).
    // rst_at: cycle during which rst is held for one edge (0 = none).
    task automatic conv(input string tag, input logic [11:0] v, input logic ovf,
                        input logic [15:0] eb, input logic en, input logic ee,
                        input int inj_at, input int rst_at);
        int   done_cnt;
        int   done_cyc;
        int   busy_bad;
        logic exp_busy;
        done_cnt = 0;
        done_cyc = -1;
        busy_bad = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.value  = v;
        bus.ovf_in = ovf;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.value  = 12'hABC;
        bus.ovf_in = ~ovf;
        for (int c = 1; c <= 20; c++) begin
            exp_busy = (rst_at == 0) ? (c <= 13) : (c <= rst_at);
            if (bus.busy !== exp_busy) busy_bad++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    check_eq({tag, "_bcd"}, 32'(bus.bcd), 32'(eb));
                    check_eq({tag, "_neg"}, 32'(bus.neg), 32'(en));
                    check_eq({tag, "_err"}, 32'(bus.err), 32'(ee));
                end
            end
            if (inj_at != 0 && c == inj_at) begin
                bus.start  = 1'b1;
                bus.value  = 12'd999;
                bus.ovf_in = 1'b1;
            end
            if (inj_at != 0 && c == inj_at + 1) bus.start = 1'b0;
            if (rst_at != 0 && c == rst_at) rst = 1'b1;
            if (rst_at != 0 && c == rst_at + 1) begin
                rst = 1'b0;
                check_eq({tag, "_rst_bcd"}, 32'(bus.bcd), 32'h0);
                check_eq({tag, "_rst_neg"}, 32'(bus.neg), 32'h0);
                check_eq({tag, "_rst_err"}, 32'(bus.err), 32'h0);
                check_eq({tag, "_rst_busy"}, 32'(bus.busy), 32'h0);
            end
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
        if (rst_at == 0) begin
            check_eq({tag, "_done_cycle"}, 32'(done_cyc), 32'd13);
            check_eq({tag, "_done_count"}, 32'(done_cnt), 32'd1);
            check_eq({tag, "_bcd_hold"}, 32'(bus.bcd), 32'(eb));
            check_eq({tag, "_neg_hold"}, 32'(bus.neg), 32'(en));
        end else begin
            check_eq({tag, "_done_count"}, 32'(done_cnt), 32'd0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.value  = '0;
        bus.ovf_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", 32'(bus.busy), 32'h0);
        check_eq("reset_done", 32'(bus.done), 32'h0);
        check_eq("reset_bcd",  32'(bus.bcd),  32'h0);
        check_eq("reset_neg",  32'(bus.neg),  32'h0);
        check_eq("reset_err",  32'(bus.err),  32'h0);
        rst = 1'b0;

        conv("zero",     12'd0,    1'b0, 16'h0000, 1'b0, 1'b0, 0, 0);
        conv("max_pos",  12'h7FF,  1'b0, 16'h2047, 1'b0, 1'b0, 0, 0);
        conv("minus1",   12'hFFF,  1'b0, 16'h0001, 1'b1, 1'b0, 0, 0);
        conv("min_neg",  12'h800,  1'b0, 16'h2048, 1'b1, 1'b0, 0, 0);
        conv("abort",    12'd500,  1'b0, 16'h0000, 1'b0, 1'b0, 0, 6);
        conv("after_rst",12'd42,   1'b0, 16'h0042, 1'b0, 1'b0, 0, 0);
        conv("ovf",      12'd37,   1'b1, 16'h0037, 1'b0, 1'b1, 0, 0);
        conv("ignored",  12'd123,  1'b0, 16'h0123, 1'b0, 1'b0, 5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
